// File: rtl/hps_fifo_pkg.sv
// Shared types and constants for the HPS<->FPGA FIFO client.
package hps_fifo_pkg;

  localparam logic [2:0] CSR_FILL_LEVEL = 3'd0;
  localparam int         CSR_RD_LAT     = 1;

  typedef enum logic [1:0] {R_POLL, R_WAIT, R_DRAIN, R_GAP} rx_state_t;
  typedef enum logic [1:0] {T_POLL, T_WAIT, T_FILL, T_GAP} tx_state_t;

endpackage

// File: rtl/hps_fifo_poll.sv
// Fill-level poll helper: gated CSR read strobe, saturated level, idle-gap down-counter.
module hps_fifo_poll #(
  parameter int DEPTH    = 256,
  parameter int POLL_GAP = 4,
  parameter int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             poll_i,
  input  logic             gap_i,
  input  logic [31:0]      csr_readdata_i,
  output logic             csr_read_o,
  output logic             gap_done_o,
  output logic [LVL_W-1:0] lvl_o
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic             en_q;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  // en_q keeps the poll strobe low until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q      <= 1'b0;
      gap_cnt_q <= GAP_W'(POLL_GAP - 1);
    end else begin
      en_q      <= 1'b1;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    gap_cnt_d = GAP_W'(POLL_GAP - 1);
    if (gap_i && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end else if (gap_i) begin
      gap_cnt_d = gap_cnt_q;
    end
  end

  assign csr_read_o = poll_i & en_q;
  assign gap_done_o = gap_i & (gap_cnt_q == '0);
  assign lvl_o      = (csr_readdata_i > 32'(DEPTH)) ? LVL_W'(DEPTH)
                                                    : csr_readdata_i[LVL_W-1:0];

endmodule

// File: rtl/hps_fifo_client.sv
// Fabric-side client: drains the HPS-to-FPGA FIFO onto m_*, fills the FPGA-to-HPS FIFO from s_*.
// state   | meaning
// R/T_POLL | issue one fill-level CSR read
// R/T_WAIT | capture level -> credit (RX) or free space (TX)
// R_DRAIN  | read words while credit remains and the 2-entry buffer has room
// T_FILL   | accept stream words while space remains
// R/T_GAP  | idle POLL_GAP cycles before the next poll
import hps_fifo_pkg::*;

module hps_fifo_client #(
  parameter int DEPTH    = 256,
  parameter int POLL_GAP = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  output logic        h2f_read,
  input  logic [31:0] h2f_readdata,
  output logic [2:0]  h2f_csr_address,
  output logic        h2f_csr_read,
  input  logic [31:0] h2f_csr_readdata,
  output logic        h2f_csr_write,
  output logic [31:0] h2f_csr_writedata,
  output logic        f2h_write,
  output logic [31:0] f2h_writedata,
  output logic [2:0]  f2h_csr_address,
  output logic        f2h_csr_read,
  input  logic [31:0] f2h_csr_readdata,
  output logic        f2h_csr_write,
  output logic [31:0] f2h_csr_writedata,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  // ---------------- RX engine ----------------
  rx_state_t        rx_state_q, rx_state_d;
  logic [LVL_W-1:0] credit_q, credit_d;
  logic             inflight_q;
  logic [31:0]      buf_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             rx_csr_read, rx_gap_done;
  logic [LVL_W-1:0] rx_lvl;
  logic             pop, buf_pop, buf_wr, rd_issue;
  logic [1:0]       occ_after;

  hps_fifo_poll #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .LVL_W(LVL_W)) u_rx_poll (
    .clk_i          (clk_clk),
    .rst_n_i        (reset_reset_n),
    .poll_i         (rx_state_q == R_POLL),
    .gap_i          (rx_state_q == R_GAP),
    .csr_readdata_i (h2f_csr_readdata),
    .csr_read_o     (rx_csr_read),
    .gap_done_o     (rx_gap_done),
    .lvl_o          (rx_lvl)
  );

  // A word landing into an empty buffer is presented directly from h2f_readdata.
  assign m_valid   = (cnt_q != 2'd0) | inflight_q;
  assign m_data    = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : (inflight_q ? h2f_readdata : 32'd0);
  assign pop       = m_valid & m_ready;
  assign buf_pop   = pop & (cnt_q != 2'd0);
  assign buf_wr    = inflight_q & ~(pop & (cnt_q == 2'd0));
  assign occ_after = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_issue  = (rx_state_q == R_DRAIN) && (credit_q != '0) && (occ_after < 2'd2);

  always_comb begin
    rx_state_d = rx_state_q;
    credit_d   = credit_q;
    case (rx_state_q)
      R_POLL:  if (rx_csr_read) rx_state_d = R_WAIT;
      R_WAIT: begin
        credit_d   = rx_lvl;
        rx_state_d = (rx_lvl == '0) ? R_GAP : R_DRAIN;
      end
      R_DRAIN: begin
        if (rd_issue) credit_d = credit_q - 1'b1;
        if ((credit_q == '0) && !inflight_q) rx_state_d = R_POLL;
      end
      R_GAP:   if (rx_gap_done) rx_state_d = R_POLL;
      default: rx_state_d = R_POLL;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_state_q <= R_POLL;
      credit_q   <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      rx_state_q <= rx_state_d;
      credit_q   <= credit_d;
      inflight_q <= rd_issue;
      if (buf_wr) begin
        buf_q[wr_ptr_q] <= h2f_readdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (buf_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, buf_wr} - {1'b0, buf_pop};
    end
  end

  assign h2f_read          = rd_issue;
  assign h2f_csr_read      = rx_csr_read;
  assign h2f_csr_address   = CSR_FILL_LEVEL;
  assign h2f_csr_write     = 1'b0;
  assign h2f_csr_writedata = 32'd0;

  // ---------------- TX engine ----------------
  tx_state_t        tx_state_q, tx_state_d;
  logic [LVL_W-1:0] space_q, space_d;
  logic             tx_csr_read, tx_gap_done;
  logic [LVL_W-1:0] tx_lvl, tx_space;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic             hs;

  hps_fifo_poll #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .LVL_W(LVL_W)) u_tx_poll (
    .clk_i          (clk_clk),
    .rst_n_i        (reset_reset_n),
    .poll_i         (tx_state_q == T_POLL),
    .gap_i          (tx_state_q == T_GAP),
    .csr_readdata_i (f2h_csr_readdata),
    .csr_read_o     (tx_csr_read),
    .gap_done_o     (tx_gap_done),
    .lvl_o          (tx_lvl)
  );

  assign tx_space = LVL_W'(DEPTH) - tx_lvl;
  assign s_ready  = (tx_state_q == T_FILL) && (space_q != '0);
  assign hs       = s_valid & s_ready;

  // Leaving T_FILL one cycle after space hits 0 keeps the re-poll off the final write strobe.
  always_comb begin
    tx_state_d = tx_state_q;
    space_d    = space_q;
    case (tx_state_q)
      T_POLL:  if (tx_csr_read) tx_state_d = T_WAIT;
      T_WAIT: begin
        space_d    = tx_space;
        tx_state_d = (tx_space == '0) ? T_GAP : T_FILL;
      end
      T_FILL: begin
        if (hs) space_d = space_q - 1'b1;
        if (space_q == '0) tx_state_d = T_POLL;
      end
      T_GAP:   if (tx_gap_done) tx_state_d = T_POLL;
      default: tx_state_d = T_POLL;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_state_q <= T_POLL;
      space_q    <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      space_q    <= space_d;
      wr_q       <= hs;
      if (hs) wdata_q <= s_data;
    end
  end

  assign f2h_write         = wr_q;
  assign f2h_writedata     = wdata_q;
  assign f2h_csr_read      = tx_csr_read;
  assign f2h_csr_address   = CSR_FILL_LEVEL;
  assign f2h_csr_write     = 1'b0;
  assign f2h_csr_writedata = 32'd0;

endmodule

// File: tb/tb_hps_fifo_client.sv
// Directed bench for hps_fifo_client with a small model of both HPS FIFOs.
`timescale 1ns/1ps
module tb_hps_fifo_client;

  localparam int DEPTH    = 256;
  localparam int POLL_GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        h2f_read, h2f_csr_read, h2f_csr_write;
  logic [2:0]  h2f_csr_address, f2h_csr_address;
  logic [31:0] h2f_readdata = '0, h2f_csr_readdata = '0, h2f_csr_writedata;
  logic        f2h_write, f2h_csr_read, f2h_csr_write;
  logic [31:0] f2h_writedata, f2h_csr_readdata = '0, f2h_csr_writedata;
  logic [31:0] m_data, s_data = 32'h5000_0000;
  logic        m_valid, m_ready = 1'b1, s_valid = 1'b0, s_ready;

  always #5 clk = ~clk;

  hps_fifo_client #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP)) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .h2f_read          (h2f_read),
    .h2f_readdata      (h2f_readdata),
    .h2f_csr_address   (h2f_csr_address),
    .h2f_csr_read      (h2f_csr_read),
    .h2f_csr_readdata  (h2f_csr_readdata),
    .h2f_csr_write     (h2f_csr_write),
    .h2f_csr_writedata (h2f_csr_writedata),
    .f2h_write         (f2h_write),
    .f2h_writedata     (f2h_writedata),
    .f2h_csr_address   (f2h_csr_address),
    .f2h_csr_read      (f2h_csr_read),
    .f2h_csr_readdata  (f2h_csr_readdata),
    .f2h_csr_write     (f2h_csr_write),
    .f2h_csr_writedata (f2h_csr_writedata),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready)
  );

  int checks = 0, errors = 0;
  logic [31:0] rx_q[$], exp_q[$];
  int tx_level = 0, mrdy_low = 0, vcyc = 0;
  int n_rd, n_rd_low, n_words, n_wr, n_hs, n_rx_poll, n_tx_poll;
  logic rd_s, rcsr_s, tcsr_s, hs_s, hs_prev = 1'b0;
  logic [31:0] hs_data_prev = '0, exp_w;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int got, input int min);
    checks++;
    if (got < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, got, min);
    end
  endtask

  task automatic chk_hex(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk_hex({tag, " strobes"},
            64'({h2f_read, h2f_csr_read, h2f_csr_write, f2h_write, f2h_csr_read,
                 f2h_csr_write, m_valid, s_ready, h2f_csr_address, f2h_csr_address}), 64'd0);
    chk_hex({tag, " data"}, {m_data, f2h_writedata}, 64'd0);
    chk_hex({tag, " csr_wdata"}, {h2f_csr_writedata, f2h_csr_writedata}, 64'd0);
  endtask

  // HPS FIFO model plus protocol monitor: sample at negedge, respond just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      vcyc++;
      rd_s   = h2f_read;
      rcsr_s = h2f_csr_read;
      tcsr_s = f2h_csr_read;
      hs_s   = s_valid & s_ready;
      if (h2f_read) begin
        n_rd++;
        if (!m_ready) n_rd_low++;
      end
      if (h2f_csr_read) n_rx_poll++;
      if (f2h_csr_read) n_tx_poll++;
      if (h2f_read | h2f_csr_read) begin
        checks++;
        if (h2f_read & h2f_csr_read) begin
          errors++;
          $display("FAIL h2f_strobe_overlap: got read=1 csr_read=1 expected one");
        end
      end
      if (f2h_write | f2h_csr_read) begin
        checks++;
        if (f2h_write & f2h_csr_read) begin
          errors++;
          $display("FAIL f2h_strobe_overlap: got write=1 csr_read=1 expected one");
        end
      end
      if (m_valid && m_ready) begin
        n_words++;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        chk_hex("rx_data", 64'(m_data), 64'(exp_w));
      end
      if (f2h_write) begin
        n_wr++;
        tx_level++;
        checks++;
        if (!hs_prev || (f2h_writedata !== hs_data_prev)) begin
          errors++;
          $display("FAIL tx_write: got data %h after_hs=%0d expected %h after_hs=1",
                   f2h_writedata, hs_prev, hs_data_prev);
        end
      end
      if (hs_s) n_hs++;
      hs_prev      = hs_s;
      hs_data_prev = s_data;
      @(posedge clk);
      #1;
      if (rd_s) h2f_readdata = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hBAD0_0000;
      if (rcsr_s) h2f_csr_readdata = 32'(rx_q.size());
      if (tcsr_s) f2h_csr_readdata = 32'(tx_level);
      if (hs_s) s_data = s_data + 32'd1;
      m_ready = (vcyc >= mrdy_low);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_vec(input int rxl, input int txl, input int mrl, input logic sv,
                           input logic [31:0] base);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    rx_q.delete();
    exp_q.delete();
    for (int k = 0; k < rxl; k++) begin
      rx_q.push_back(base + 32'(k));
      exp_q.push_back(base + 32'(k));
    end
    tx_level = txl;
    mrdy_low = mrl;
    repeat (2) @(posedge clk);
    #2;
    n_rd = 0; n_rd_low = 0; n_words = 0; n_wr = 0; n_hs = 0; n_rx_poll = 0; n_tx_poll = 0;
    vcyc    = 0;
    rst_n   = 1'b1;
    s_valid = sv;
  endtask

  typedef struct {
    int rx_lvl; int tx_lvl; int mrdy_low; int sv; int cycles;
    int exp_rd; int exp_rd_low; int exp_words; int exp_wr; int min_rxp; int min_txp;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   rxp[$], txp[$];
    bit   ok, first_csr;

    //            rx     tx       mrl sv cyc  rd   rdl wds  wr   rxp txp
    vecs[0] = '{3,     DEPTH,   0,  0, 40,  3,   0,  3,   0,   2,  5};
    vecs[1] = '{5,     DEPTH,   10, 0, 50,  5,   2,  5,   0,   2,  5};
    vecs[2] = '{0,     DEPTH,   0,  0, 40,  0,   0,  0,   0,   5,  5};
    vecs[3] = '{0,     DEPTH-2, 0,  1, 40,  0,   0,  0,   2,   5,  2};
    vecs[4] = '{0,     DEPTH,   0,  1, 40,  0,   0,  0,   0,   5,  5};
    vecs[5] = '{DEPTH, DEPTH,   0,  0, 300, DEPTH, 0, DEPTH, 0, 2,  5};
    vecs[6] = '{0,     0,       0,  1, 300, 0,   0,  0,   DEPTH, 5, 2};
    vecs[7] = '{2,     DEPTH-1, 0,  1, 40,  2,   0,  2,   1,   2,  2};

    h2f_readdata     = 32'hFFFF_FFFF;
    h2f_csr_readdata = 32'd7;
    f2h_csr_readdata = 32'd7;
    s_valid          = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk_zero("reset");
    @(posedge clk);
    #2;

    for (int i = 0; i < 8; i++) begin
      start_vec(vecs[i].rx_lvl, vecs[i].tx_lvl, vecs[i].mrdy_low, vecs[i].sv[0],
                32'(i + 1) << 24);
      repeat (vecs[i].cycles) @(posedge clk);
      #2;
      chk($sformatf("v%0d h2f_reads", i), n_rd, vecs[i].exp_rd);
      chk($sformatf("v%0d words", i), n_words, vecs[i].exp_words);
      chk($sformatf("v%0d f2h_writes", i), n_wr, vecs[i].exp_wr);
      chk($sformatf("v%0d handshakes", i), n_hs, vecs[i].exp_wr);
      chk_ge($sformatf("v%0d rx_polls", i), n_rx_poll, vecs[i].min_rxp);
      chk_ge($sformatf("v%0d tx_polls", i), n_tx_poll, vecs[i].min_txp);
      if (vecs[i].mrdy_low > 0)
        chk($sformatf("v%0d reads_while_stalled", i), n_rd_low, vecs[i].exp_rd_low);
    end

    // Poll period with RX empty and TX full.
    start_vec(0, DEPTH, 0, 1'b0, 32'h0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (h2f_csr_read) rxp.push_back(c);
      if (f2h_csr_read) txp.push_back(c);
    end
    chk_ge("rx_poll_count", rxp.size(), 4);
    chk_ge("tx_poll_count", txp.size(), 4);
    for (int k = 1; k < 4 && k < rxp.size(); k++)
      chk($sformatf("rx_poll_period%0d", k), rxp[k] - rxp[k-1], POLL_GAP + 2);
    for (int k = 1; k < 4 && k < txp.size(); k++)
      chk($sformatf("tx_poll_period%0d", k), txp[k] - txp[k-1], POLL_GAP + 2);
    @(posedge clk);
    #2;

    // Reset with one read in flight; the lost word must not be replayed.
    start_vec(4, DEPTH, 0, 1'b0, 32'hC000_0000);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (h2f_read) begin
        ok = 1'b1;
        break;
      end
    end
    chk("first_read_seen", int'(ok), 1);
    @(posedge clk);
    #2;
    chk_hex("first_word_latency", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'hC000_0000});
    #1 rst_n = 1'b0;
    #1;
    chk_zero("mid_drain_reset");
    exp_q = rx_q;
    repeat (2) @(posedge clk);
    #2;
    n_words = 0;
    rst_n   = 1'b1;
    ok = 1'b0;
    first_csr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (h2f_read | h2f_csr_read | m_valid) begin
        ok = 1'b1;
        first_csr = h2f_csr_read & ~h2f_read & ~m_valid;
        break;
      end
    end
    chk("post_reset_activity", int'(ok), 1);
    chk("post_reset_first_is_poll", int'(first_csr), 1);
    repeat (40) @(posedge clk);
    #2;
    chk("post_reset_words", n_words, 3);
    chk("post_reset_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
